// File: rtl/sampler_cfg_pkg.sv
// rtl/sampler_cfg_pkg.sv - shared widths and FSM state type for the sampler config synchroniser
package sampler_cfg_pkg;

  localparam int P1DIV_W = 12;
  localparam int P1CNT_W = 4;
  localparam int P2CNT_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

endpackage : sampler_cfg_pkg

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - generic multi-stage single-bit synchroniser with async active-low clear
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule : sync_ff

// File: rtl/sampler_cfg_sync.sv
// rtl/sampler_cfg_sync.sv - synchronises divider reset/enable and applies config updates at safe points
module sampler_cfg_sync
  import sampler_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               HF_CLK,
  input  logic               NRST,
  input  logic               ENSAMP,
  input  logic               TEMP_RUN,
  input  logic [P1DIV_W-1:0] PHASE1DIV1,
  input  logic [P1CNT_W-1:0] PHASE1COUNT,
  input  logic [P2CNT_W-1:0] PHASE2COUNT,
  input  logic               CFG_UPD_REQ,
  input  logic               phase,
  output logic               NRST_sync,
  output logic               ENSAMP_sync,
  output logic [P1DIV_W-1:0] PHASE1DIV1_sync,
  output logic [P1CNT_W-1:0] PHASE1COUNT_sync,
  output logic [P2CNT_W-1:0] PHASE2COUNT_sync,
  output logic               CFG_UPD_ACK,
  output logic               CFG_PENDING,
  output logic               CFG_OVERRUN
);

  state_e             state_q, state_d;
  logic [P1DIV_W-1:0] p1div_q, p1div_d;
  logic [P1CNT_W-1:0] p1cnt_q, p1cnt_d;
  logic [P2CNT_W-1:0] p2cnt_q, p2cnt_d;
  logic               ack_q, ack_d;
  logic               overrun_q, overrun_d;
  logic               req_hist_q;
  logic               phase_dly_q;
  logic               req_sync;
  logic               req_edge;
  logic               phase_rise;
  logic               en;
  logic               imm;
  logic               load;

  // Reset release chain: D tied high, cleared asynchronously by the raw reset.
  sync_ff #(.STAGES(SYNC_STAGES)) u_nrst_sync (
    .clk_i  (HF_CLK),
    .rst_ni (NRST),
    .d_i    (1'b1),
    .q_o    (NRST_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_ensamp_sync (
    .clk_i  (HF_CLK),
    .rst_ni (NRST),
    .d_i    (ENSAMP),
    .q_o    (ENSAMP_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i  (HF_CLK),
    .rst_ni (NRST),
    .d_i    (CFG_UPD_REQ),
    .q_o    (req_sync)
  );

  assign en         = ENSAMP_sync | TEMP_RUN;
  assign req_edge   = req_sync ^ req_hist_q;
  assign phase_rise = phase & ~phase_dly_q;
  // Without a silence boundary there is no safer moment than now.
  assign imm        = (p1div_q == '0) || (p2cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (req_edge) begin
          if (!en || imm) begin
            load = 1'b1;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (phase_rise || !en || imm) begin
          load    = 1'b1;
          state_d = IDLE;
        end
        if (req_edge) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p1div_d = p1div_q;
    p1cnt_d = p1cnt_q;
    p2cnt_d = p2cnt_q;
    ack_d   = ack_q;
    if (load) begin
      p1div_d = PHASE1DIV1;
      p1cnt_d = PHASE1COUNT;
      p2cnt_d = PHASE2COUNT;
      ack_d   = ~ack_q;
    end
  end

  always_ff @(posedge HF_CLK or negedge NRST) begin
    if (!NRST) begin
      state_q     <= IDLE;
      p1div_q     <= '0;
      p1cnt_q     <= '0;
      p2cnt_q     <= '0;
      ack_q       <= 1'b0;
      overrun_q   <= 1'b0;
      req_hist_q  <= 1'b0;
      phase_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1div_q     <= p1div_d;
      p1cnt_q     <= p1cnt_d;
      p2cnt_q     <= p2cnt_d;
      ack_q       <= ack_d;
      overrun_q   <= overrun_d;
      req_hist_q  <= req_sync;
      phase_dly_q <= phase;
    end
  end

  assign PHASE1DIV1_sync  = p1div_q;
  assign PHASE1COUNT_sync = p1cnt_q;
  assign PHASE2COUNT_sync = p2cnt_q;
  assign CFG_UPD_ACK      = ack_q;
  assign CFG_PENDING      = (state_q == PEND);
  assign CFG_OVERRUN      = overrun_q;

endmodule : sampler_cfg_sync

// File: tb/tb_sampler_cfg_sync.sv
// tb/tb_sampler_cfg_sync.sv - directed self-checking bench for sampler_cfg_sync
module tb_sampler_cfg_sync;

  logic        HF_CLK = 1'b0;
  logic        NRST;
  logic        ENSAMP;
  logic        TEMP_RUN;
  logic [11:0] PHASE1DIV1;
  logic [3:0]  PHASE1COUNT;
  logic [9:0]  PHASE2COUNT;
  logic        CFG_UPD_REQ;
  logic        phase;
  logic        NRST_sync;
  logic        ENSAMP_sync;
  logic [11:0] PHASE1DIV1_sync;
  logic [3:0]  PHASE1COUNT_sync;
  logic [9:0]  PHASE2COUNT_sync;
  logic        CFG_UPD_ACK;
  logic        CFG_PENDING;
  logic        CFG_OVERRUN;

  int total  = 0;
  int passed = 0;

  sampler_cfg_sync #(.SYNC_STAGES(2)) dut (
    .HF_CLK           (HF_CLK),
    .NRST             (NRST),
    .ENSAMP           (ENSAMP),
    .TEMP_RUN         (TEMP_RUN),
    .PHASE1DIV1       (PHASE1DIV1),
    .PHASE1COUNT      (PHASE1COUNT),
    .PHASE2COUNT      (PHASE2COUNT),
    .CFG_UPD_REQ      (CFG_UPD_REQ),
    .phase            (phase),
    .NRST_sync        (NRST_sync),
    .ENSAMP_sync      (ENSAMP_sync),
    .PHASE1DIV1_sync  (PHASE1DIV1_sync),
    .PHASE1COUNT_sync (PHASE1COUNT_sync),
    .PHASE2COUNT_sync (PHASE2COUNT_sync),
    .CFG_UPD_ACK      (CFG_UPD_ACK),
    .CFG_PENDING      (CFG_PENDING),
    .CFG_OVERRUN      (CFG_OVERRUN)
  );

  always #5 HF_CLK = ~HF_CLK;

  task automatic tick();
    @(posedge HF_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_cfg(input string tag, input logic [11:0] d, input logic [3:0] c1,
                         input logic [9:0] c2);
    chk({tag, "_p1div"}, {4'h0, PHASE1DIV1_sync}, {4'h0, d});
    chk({tag, "_p1cnt"}, {12'h0, PHASE1COUNT_sync}, {12'h0, c1});
    chk({tag, "_p2cnt"}, {6'h0, PHASE2COUNT_sync}, {6'h0, c2});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nrst_sync"}, {15'h0, NRST_sync}, 16'h0);
    chk({tag, "_en_sync"}, {15'h0, ENSAMP_sync}, 16'h0);
    chk_cfg(tag, 12'h0, 4'h0, 10'h0);
    chk({tag, "_ack"}, {15'h0, CFG_UPD_ACK}, 16'h0);
    chk({tag, "_pend"}, {15'h0, CFG_PENDING}, 16'h0);
    chk({tag, "_ovr"}, {15'h0, CFG_OVERRUN}, 16'h0);
  endtask

  task automatic set_cfg(input logic [11:0] d, input logic [3:0] c1, input logic [9:0] c2);
    PHASE1DIV1  = d;
    PHASE1COUNT = c1;
    PHASE2COUNT = c2;
  endtask

  initial begin
    NRST = 1'b0; ENSAMP = 1'b0; TEMP_RUN = 1'b0; CFG_UPD_REQ = 1'b0; phase = 1'b0;
    set_cfg(12'd0, 4'd0, 10'd0);
    tick(); tick();
    chk_all_zero("reset");

    // Reset release: NRST_sync rises after exactly two edges.
    NRST = 1'b1;
    tick();
    chk("rel_e1_nrst_sync", {15'h0, NRST_sync}, 16'h0);
    tick();
    chk("rel_e2_nrst_sync", {15'h0, NRST_sync}, 16'h1);
    chk("rel_e2_ack", {15'h0, CFG_UPD_ACK}, 16'h0);

    // Disabled update: load two edges after the toggle enters stage 1.
    set_cfg(12'd5, 4'd3, 10'd8);
    CFG_UPD_REQ = 1'b1;
    tick();
    chk("dis_k0_ack", {15'h0, CFG_UPD_ACK}, 16'h0);
    chk("dis_k0_pend", {15'h0, CFG_PENDING}, 16'h0);
    tick();
    chk("dis_k1_ack", {15'h0, CFG_UPD_ACK}, 16'h0);
    chk("dis_k1_pend", {15'h0, CFG_PENDING}, 16'h0);
    chk_cfg("dis_k1", 12'd0, 4'd0, 10'd0);
    tick();
    chk("dis_k2_ack", {15'h0, CFG_UPD_ACK}, 16'h1);
    chk("dis_k2_pend", {15'h0, CFG_PENDING}, 16'h0);
    chk_cfg("dis_k2", 12'd5, 4'd3, 10'd8);

    // Running update waits for phase rise.
    ENSAMP = 1'b1;
    tick();
    chk("en_lat_e1", {15'h0, ENSAMP_sync}, 16'h0);
    tick();
    chk("en_lat_e2", {15'h0, ENSAMP_sync}, 16'h1);
    set_cfg(12'd7, 4'd2, 10'd4);
    CFG_UPD_REQ = 1'b0;
    tick(); tick();
    chk("run_k1_pend", {15'h0, CFG_PENDING}, 16'h0);
    tick();
    chk("run_k2_pend", {15'h0, CFG_PENDING}, 16'h1);
    chk_cfg("run_k2", 12'd5, 4'd3, 10'd8);
    tick(); tick(); tick();
    chk("run_wait_pend", {15'h0, CFG_PENDING}, 16'h1);
    chk("run_wait_ack", {15'h0, CFG_UPD_ACK}, 16'h1);
    chk_cfg("run_wait", 12'd5, 4'd3, 10'd8);
    phase = 1'b1;
    tick();
    chk_cfg("run_load", 12'd7, 4'd2, 10'd4);
    chk("run_load_ack", {15'h0, CFG_UPD_ACK}, 16'h0);
    chk("run_load_pend", {15'h0, CFG_PENDING}, 16'h0);
    tick();
    phase = 1'b0;
    tick();

    // TEMP_RUN keeps en high, so the pending update must hold.
    TEMP_RUN = 1'b1;
    set_cfg(12'd11, 4'd4, 10'd12);
    CFG_UPD_REQ = 1'b1;
    tick(); tick(); tick();
    chk("tr_pend", {15'h0, CFG_PENDING}, 16'h1);
    ENSAMP = 1'b0;
    tick(); tick(); tick(); tick();
    chk("tr_hold_pend", {15'h0, CFG_PENDING}, 16'h1);
    chk("tr_hold_en_sync", {15'h0, ENSAMP_sync}, 16'h0);
    chk_cfg("tr_hold", 12'd7, 4'd2, 10'd4);
    TEMP_RUN = 1'b0;
    tick();
    chk_cfg("tr_load", 12'd11, 4'd4, 10'd12);
    chk("tr_load_ack", {15'h0, CFG_UPD_ACK}, 16'h1);
    chk("tr_load_pend", {15'h0, CFG_PENDING}, 16'h0);

    // ENSAMP drop while pending: en is 0 after two edges, load on the next.
    ENSAMP = 1'b1;
    tick(); tick();
    set_cfg(12'd13, 4'd5, 10'd20);
    CFG_UPD_REQ = 1'b0;
    tick(); tick(); tick();
    chk("dp_pend", {15'h0, CFG_PENDING}, 16'h1);
    ENSAMP = 1'b0;
    tick();
    chk("dp_e1_pend", {15'h0, CFG_PENDING}, 16'h1);
    tick();
    chk("dp_e2_pend", {15'h0, CFG_PENDING}, 16'h1);
    chk_cfg("dp_e2", 12'd11, 4'd4, 10'd12);
    tick();
    chk_cfg("dp_e3", 12'd13, 4'd5, 10'd20);
    chk("dp_e3_ack", {15'h0, CFG_UPD_ACK}, 16'h0);
    chk("dp_e3_pend", {15'h0, CFG_PENDING}, 16'h0);

    // Immediate mode: applied PHASE2COUNT 0 with en high loads at once.
    set_cfg(12'd6, 4'd2, 10'd0);
    CFG_UPD_REQ = 1'b1;
    tick(); tick(); tick();
    chk_cfg("imm_setup", 12'd6, 4'd2, 10'd0);
    chk("imm_setup_ack", {15'h0, CFG_UPD_ACK}, 16'h1);
    ENSAMP = 1'b1;
    tick(); tick();
    set_cfg(12'd9, 4'd1, 10'd6);
    CFG_UPD_REQ = 1'b0;
    tick();
    chk("imm_k0_pend", {15'h0, CFG_PENDING}, 16'h0);
    tick();
    chk("imm_k1_pend", {15'h0, CFG_PENDING}, 16'h0);
    tick();
    chk("imm_k2_pend", {15'h0, CFG_PENDING}, 16'h0);
    chk_cfg("imm_k2", 12'd9, 4'd1, 10'd6);
    chk("imm_k2_ack", {15'h0, CFG_UPD_ACK}, 16'h0);

    // Overrun: second toggle while pending, one ACK toggle total.
    set_cfg(12'd3, 4'd2, 10'd1);
    CFG_UPD_REQ = 1'b1;
    tick(); tick(); tick();
    chk("ovr_pend", {15'h0, CFG_PENDING}, 16'h1);
    chk("ovr_before", {15'h0, CFG_OVERRUN}, 16'h0);
    set_cfg(12'd4, 4'd3, 10'd2);
    CFG_UPD_REQ = 1'b0;
    tick(); tick();
    chk("ovr_k1", {15'h0, CFG_OVERRUN}, 16'h0);
    tick();
    chk("ovr_k2", {15'h0, CFG_OVERRUN}, 16'h1);
    chk("ovr_k2_pend", {15'h0, CFG_PENDING}, 16'h1);
    chk("ovr_k2_ack", {15'h0, CFG_UPD_ACK}, 16'h0);
    phase = 1'b1;
    tick();
    chk_cfg("ovr_load", 12'd4, 4'd3, 10'd2);
    chk("ovr_load_ack", {15'h0, CFG_UPD_ACK}, 16'h1);
    chk("ovr_load_pend", {15'h0, CFG_PENDING}, 16'h0);
    tick(); tick(); tick();
    chk("ovr_after_ack", {15'h0, CFG_UPD_ACK}, 16'h1);
    chk("ovr_after_sticky", {15'h0, CFG_OVERRUN}, 16'h1);

    // Mid-run reset clears everything without a clock edge.
    CFG_UPD_REQ = 1'b1;
    ENSAMP = 1'b0;
    phase = 1'b0;
    NRST = 1'b0;
    #1;
    chk_all_zero("midrst");
    NRST = 1'b1;
    tick();
    chk("midrel_e1_nrst_sync", {15'h0, NRST_sync}, 16'h0);
    tick();
    chk("midrel_e2_nrst_sync", {15'h0, NRST_sync}, 16'h1);
    chk("midrel_e2_ack", {15'h0, CFG_UPD_ACK}, 16'h0);
    tick();
    // REQ held at 1 through reset is seen as a request, realigning ACK.
    chk("midrel_e3_ack", {15'h0, CFG_UPD_ACK}, 16'h1);
    chk_cfg("midrel_e3", 12'd4, 4'd3, 10'd2);
    chk("midrel_e3_ovr", {15'h0, CFG_OVERRUN}, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sampler_cfg_sync
